// File: rtl/intf_arb_pkg.sv
// rtl/intf_arb_pkg.sv - shared types and helpers for the round-robin stream arbiter
// Purpose: arbitration state encoding and the mod-n pointer increment.
// Ports: none (package).
package intf_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Explicit wrap instead of a bit-width overflow so a non-power-of-2 count
  // never produces an index >= n.
  function automatic int rr_next(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/intf_rr_arbiter_rr_pick.sv
// rtl/intf_rr_arbiter_rr_pick.sv - combinational N-way rotate-priority picker
// Purpose: find the first asserted request starting at ptr and wrapping mod N.
// Ports:
//   req     in   N          request vector
//   ptr     in   clog2(N)   highest-priority index this cycle
//   gnt_idx out  clog2(N)   winning index (0 when nothing requests)
//   gnt_any out  1          at least one request present
module rr_pick #(
  parameter int N = 6
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int PW = $clog2(N);

  // Walk the search order backwards so the candidate closest to ptr is the
  // last assignment and therefore wins.
  always_comb begin
    int idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[PW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/intf_rr_arbiter.sv
// rtl/intf_rr_arbiter.sv - N-channel round-robin valid/ready stream arbiter
// Purpose: merge N input streams into one registered output stream, with
//          optional packet locking until the in_last beat.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  N-bit per-channel handshake
//   in_data         N*W, channel i at [i*W +: W]
//   in_last         N-bit per-channel end-of-packet
//   out_valid/ready output handshake
//   out_data/last   registered beat payload
//   out_chan        source channel of the current output beat
module intf_rr_arbiter
  import intf_arb_pkg::*;
#(
  parameter int N         = 6,
  parameter int W         = 8,
  parameter int LOCK_LAST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_chan
);

  localparam int PW = $clog2(N);

  arb_state_e    state, state_next;
  logic [PW-1:0] ptr, lock_chan, lock_next;
  logic [PW-1:0] pick_idx, grant;
  logic          pick_any, grant_any;
  logic          free, xfer, grant_last;

  rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // While locked only the owning channel may move, even if it idles.
  always_comb begin
    grant     = pick_idx;
    grant_any = pick_any;
    if (state == LOCKED) begin
      grant     = lock_chan;
      grant_any = in_valid[lock_chan];
    end
  end

  assign free       = !out_valid || out_ready;
  assign xfer       = !rst && free && grant_any;
  assign in_ready   = xfer ? (N'(1) << grant) : '0;
  assign grant_last = in_last[grant];

  always_comb begin
    state_next = state;
    lock_next  = lock_chan;
    if (LOCK_LAST != 0 && xfer) begin
      case (state)
        ARB: begin
          if (!grant_last) begin
            state_next = LOCKED;
            lock_next  = grant;
          end
        end
        LOCKED: begin
          if (grant_last) state_next = ARB;
        end
        default: state_next = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      lock_chan <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      state     <= state_next;
      lock_chan <= lock_next;
      if (xfer && (LOCK_LAST == 0 || grant_last)) begin
        ptr <= PW'(rr_next(int'(grant), N));
      end
      if (free) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= in_data[int'(grant)*W +: W];
          out_last <= grant_last;
          out_chan <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_intf_rr_arbiter.sv
// tb/tb_intf_rr_arbiter.sv - directed table-driven bench for intf_rr_arbiter
module tb_intf_rr_arbiter;
  import intf_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  in_valid = 6'h3f;
  logic [5:0]  in_last = 6'h3f;
  logic [47:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic [5:0]  rdy1, rdy0;
  logic        ov1, ov0, ol1, ol0;
  logic [7:0]  od1, od0;
  logic [2:0]  oc1, oc0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  intf_rr_arbiter #(.N(6), .W(8), .LOCK_LAST(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_last(ol1), .out_chan(oc1)
  );

  intf_rr_arbiter #(.N(6), .W(8), .LOCK_LAST(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_last(ol0), .out_chan(oc0)
  );

  typedef struct {
    logic [5:0]  valid;
    logic [47:0] data;
    logic        ordy;
    logic [5:0]  exp_ready;
    logic        exp_ov;
    logic [7:0]  exp_data;
    logic [2:0]  exp_chan;
    logic [2:0]  exp_ptr;
  } vec_t;

  vec_t tv[$];

  localparam logic [47:0] D0 = 48'h15_14_13_12_11_10;
  localparam logic [47:0] DB = 48'h15_14_13_12_5A_10;

  function automatic vec_t mkv(logic [5:0] v, logic [47:0] d, logic r, logic [5:0] er,
                               logic eov, logic [7:0] ed, logic [2:0] ec, logic [2:0] ep);
    vec_t x;
    x.valid = v; x.data = d; x.ordy = r; x.exp_ready = er;
    x.exp_ov = eov; x.exp_data = ed; x.exp_chan = ec; x.exp_ptr = ep;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One cycle of a hand sequence against one instance (sel=1: locking, sel=0: non-locking).
  task automatic seq(input bit sel, input string nm, input logic [5:0] v, input logic [5:0] l,
                     input logic [47:0] d, input logic [5:0] er, input logic eov,
                     input logic [7:0] ed, input logic [2:0] ec, input logic el);
    in_valid = v; in_last = l; in_data = d; out_ready = 1'b1;
    #2;
    chk({nm, ".ready"}, sel ? rdy1 : rdy0, er);
    chk({nm, ".ov"}, sel ? ov1 : ov0, eov);
    if (eov) begin
      chk({nm, ".data"}, sel ? od1 : od0, ed);
      chk({nm, ".chan"}, sel ? oc1 : oc0, ec);
      chk({nm, ".last"}, sel ? ol1 : ol0, el);
    end
    adv();
  endtask

  task automatic rst_pulse();
    in_valid = '0;
    rst = 1'b1;
    adv();
    rst = 1'b0;
  endtask

  initial begin
    // reset held 3 cycles with every channel requesting
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ov1", ov1, 0);       chk("rst.ov0", ov0, 0);
    chk("rst.rdy1", rdy1, 0);     chk("rst.rdy0", rdy0, 0);
    chk("rst.data", od1, 0);      chk("rst.chan", oc1, 0);
    chk("rst.last", ol1, 0);
    rst = 1'b0;

    // fairness
    tv.push_back(mkv(6'h3f, D0, 1, 6'h01, 0, 8'h00, 0, 0));
    tv.push_back(mkv(6'h3f, D0, 1, 6'h02, 1, 8'h10, 0, 1));
    tv.push_back(mkv(6'h3f, D0, 1, 6'h04, 1, 8'h11, 1, 2));
    tv.push_back(mkv(6'h3f, D0, 1, 6'h08, 1, 8'h12, 2, 3));
    tv.push_back(mkv(6'h3f, D0, 1, 6'h10, 1, 8'h13, 3, 4));
    tv.push_back(mkv(6'h3f, D0, 1, 6'h20, 1, 8'h14, 4, 5));
    tv.push_back(mkv(6'h3f, D0, 1, 6'h01, 1, 8'h15, 5, 0));
    tv.push_back(mkv(6'h00, D0, 1, 6'h00, 1, 8'h10, 0, 1));
    tv.push_back(mkv(6'h00, D0, 1, 6'h00, 0, 8'h00, 0, 1));
    // backpressure
    tv.push_back(mkv(6'h02, DB, 1, 6'h02, 0, 8'h00, 0, 1));
    for (int i = 0; i < 4; i++) tv.push_back(mkv(6'h04, DB, 0, 6'h00, 1, 8'h5A, 1, 2));
    tv.push_back(mkv(6'h04, DB, 1, 6'h04, 1, 8'h5A, 1, 2));
    tv.push_back(mkv(6'h00, DB, 1, 6'h00, 1, 8'h12, 2, 3));
    tv.push_back(mkv(6'h00, DB, 1, 6'h00, 0, 8'h00, 0, 3));
    // wrap-around from ptr=5
    tv.push_back(mkv(6'h10, D0, 1, 6'h10, 0, 8'h00, 0, 3));
    tv.push_back(mkv(6'h21, D0, 1, 6'h20, 1, 8'h14, 4, 5));
    tv.push_back(mkv(6'h21, D0, 1, 6'h01, 1, 8'h15, 5, 0));
    tv.push_back(mkv(6'h21, D0, 1, 6'h20, 1, 8'h10, 0, 1));
    tv.push_back(mkv(6'h00, D0, 1, 6'h00, 1, 8'h15, 5, 0));
    tv.push_back(mkv(6'h00, D0, 1, 6'h00, 0, 8'h00, 0, 0));

    foreach (tv[i]) begin
      in_valid = tv[i].valid; in_last = 6'h3f; in_data = tv[i].data; out_ready = tv[i].ordy;
      #2;
      chk($sformatf("v%0d.ready1", i), rdy1, tv[i].exp_ready);
      chk($sformatf("v%0d.ready0", i), rdy0, tv[i].exp_ready);
      chk($sformatf("v%0d.ov1", i), ov1, tv[i].exp_ov);
      chk($sformatf("v%0d.ov0", i), ov0, tv[i].exp_ov);
      chk($sformatf("v%0d.ptr1", i), dut.ptr, tv[i].exp_ptr);
      chk($sformatf("v%0d.ptr0", i), dut0.ptr, tv[i].exp_ptr);
      if (tv[i].exp_ov) begin
        chk($sformatf("v%0d.data1", i), od1, tv[i].exp_data);
        chk($sformatf("v%0d.chan1", i), oc1, tv[i].exp_chan);
        chk($sformatf("v%0d.last1", i), ol1, 1);
        chk($sformatf("v%0d.data0", i), od0, tv[i].exp_data);
        chk($sformatf("v%0d.chan0", i), oc0, tv[i].exp_chan);
      end
      adv();
    end

    // packet lock: chan2 A0 (gap 2) A1 A2, chan3 always offering single beats
    rst_pulse();
    seq(1, "lk0", 6'h0c, 6'h08, 48'h00_00_33_A0_00_00, 6'h04, 0, 8'h00, 0, 0);
    chk("lk.state_locked", dut.state, LOCKED);
    seq(1, "lk1", 6'h08, 6'h08, 48'h00_00_33_00_00_00, 6'h00, 1, 8'hA0, 2, 0);
    seq(1, "lk2", 6'h08, 6'h08, 48'h00_00_33_00_00_00, 6'h00, 0, 8'h00, 0, 0);
    seq(1, "lk3", 6'h0c, 6'h08, 48'h00_00_33_A1_00_00, 6'h04, 0, 8'h00, 0, 0);
    seq(1, "lk4", 6'h0c, 6'h0c, 48'h00_00_33_A2_00_00, 6'h04, 1, 8'hA1, 2, 0);
    chk("lk.ptr", dut.ptr, 3);
    chk("lk.state_arb", dut.state, ARB);
    seq(1, "lk5", 6'h08, 6'h08, 48'h00_00_33_00_00_00, 6'h08, 1, 8'hA2, 2, 1);
    seq(1, "lk6", 6'h00, 6'h00, 48'h0, 6'h00, 1, 8'h33, 3, 1);
    seq(1, "lk7", 6'h00, 6'h00, 48'h0, 6'h00, 0, 8'h00, 0, 0);

    // same traffic shape without locking interleaves the channels
    rst_pulse();
    seq(0, "nl0", 6'h0c, 6'h08, 48'h00_00_33_A0_00_00, 6'h04, 0, 8'h00, 0, 0);
    seq(0, "nl1", 6'h08, 6'h08, 48'h00_00_33_00_00_00, 6'h08, 1, 8'hA0, 2, 0);
    seq(0, "nl2", 6'h08, 6'h08, 48'h00_00_33_00_00_00, 6'h08, 1, 8'h33, 3, 1);
    seq(0, "nl3", 6'h0c, 6'h08, 48'h00_00_33_A1_00_00, 6'h04, 1, 8'h33, 3, 1);
    seq(0, "nl4", 6'h0c, 6'h0c, 48'h00_00_33_A2_00_00, 6'h08, 1, 8'hA1, 2, 0);
    seq(0, "nl5", 6'h0c, 6'h0c, 48'h00_00_33_A2_00_00, 6'h04, 1, 8'h33, 3, 1);
    seq(0, "nl6", 6'h00, 6'h00, 48'h0, 6'h00, 1, 8'hA2, 2, 1);
    seq(0, "nl7", 6'h00, 6'h00, 48'h0, 6'h00, 0, 8'h00, 0, 0);

    // reset in the middle of a locked packet on chan4
    rst_pulse();
    seq(1, "rm0", 6'h10, 6'h00, 48'h00_44_00_00_00_00, 6'h10, 0, 8'h00, 0, 0);
    in_valid = 6'h02; in_last = 6'h02; in_data = 48'h00_00_00_00_11_00;
    #2;
    chk("rm1.state_locked", dut.state, LOCKED);
    chk("rm1.ready_locked", rdy1, 6'h00);
    chk("rm1.ov", ov1, 1);
    rst = 1'b1;
    #1;
    chk("rm.async_ov", ov1, 0);
    chk("rm.async_ready", rdy1, 6'h00);
    chk("rm.async_state", dut.state, ARB);
    chk("rm.async_ptr", dut.ptr, 0);
    adv();
    rst = 1'b0;
    seq(1, "rm2", 6'h02, 6'h02, 48'h00_00_00_00_11_00, 6'h02, 0, 8'h00, 0, 0);
    seq(1, "rm3", 6'h00, 6'h00, 48'h0, 6'h00, 1, 8'h11, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
